// File: rtl/lfsr_encrypt_engine.sv
// Frame encryptor: 64-byte frames of space padding + message, XORed with a 7-bit LFSR.
// Build option ENC_PARITY_EN puts the even parity of the 7 cipher bits in bit 7 of each output byte.
module lfsr_encrypt_engine (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [6:0] taps_i,
  input  logic [6:0] seed_i,
  input  logic [3:0] pre_len_i,
  input  logic [5:0] msg_len_i,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       ack_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_MSG,
    S_POST,
    S_DONE
  } state_e;

  localparam logic [6:0] FRAME_LEN = 7'd64;
  localparam logic [5:0] MSG_MAX   = 6'd49;
  localparam logic [6:0] SPACE     = 7'h20;

  state_e     state_q, state_d;
  logic [6:0] lfsr_q, lfsr_d;
  logic [5:0] idx_q, idx_d;
  logic [6:0] taps_q, taps_d;
  logic [3:0] pre_len_q, pre_len_d;
  logic [5:0] msg_len_q, msg_len_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       ack_q, ack_d;

  logic       slot_free;
  logic       start_ok;
  logic       emit;
  logic       in_ready;
  logic [5:0] msg_len_clamped;
  logic [6:0] seed_fixed;
  logic [6:0] idx_inc;
  logic [6:0] msg_end;
  logic [6:0] plain;
  logic [6:0] cipher;
  logic       parity;
  logic       unused_in_msb;

  // Plaintext is 7-bit ASCII; the top bit of the input character carries nothing.
  assign unused_in_msb = in_data_i[7];

  assign slot_free       = !out_valid_q || out_ready_i;
  assign start_ok        = start_i && (state_q == S_IDLE || state_q == S_DONE);
  assign msg_len_clamped = (msg_len_i > MSG_MAX) ? MSG_MAX : msg_len_i;
  assign seed_fixed      = (seed_i == 7'h00) ? 7'h01 : seed_i;
  assign idx_inc         = {1'b0, idx_q} + 7'd1;
  assign msg_end         = {3'b000, pre_len_q} + {1'b0, msg_len_q};

  assign plain  = (state_q == S_MSG) ? in_data_i[6:0] : SPACE;
  assign cipher = plain ^ lfsr_q;

`ifdef ENC_PARITY_EN
  assign parity = ^cipher;
`else
  assign parity = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: registers take <= so every flop samples pre-edge values, independent of block order.
      state_q <= state_d;
    end
  end

  // Next-state logic: each move happens on the emit of the last byte of a section.
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          if (pre_len_i != 4'd0) begin
            state_d = S_PRE;
          end else if (msg_len_clamped != 6'd0) begin
            state_d = S_MSG;
          end else begin
            state_d = S_POST;
          end
        end
      end
      S_PRE: begin
        if (emit && idx_inc == {3'b000, pre_len_q}) begin
          state_d = (msg_len_q != 6'd0) ? S_MSG : S_POST;
        end
      end
      S_MSG: begin
        if (emit) begin
          // A 15-byte pad plus a 49-byte message fills the frame with no trailing pad.
          if (idx_inc == FRAME_LEN) begin
            state_d = S_DONE;
          end else if (idx_inc == msg_end) begin
            state_d = S_POST;
          end
        end
      end
      S_POST: begin
        if (emit && idx_inc == FRAME_LEN) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: handshake qualifiers derived from state and the output slot.
  always_comb begin
    emit     = 1'b0;
    in_ready = 1'b0;
    unique case (state_q)
      S_PRE, S_POST: emit = slot_free;
      S_MSG: begin
        in_ready = slot_free;
        emit     = slot_free && in_valid_i;
      end
      default: begin
        emit     = 1'b0;
        in_ready = 1'b0;
      end
    endcase
  end

  // Datapath next-state: config latch, LFSR, byte index, output slot, frame ack.
  always_comb begin
    lfsr_d      = lfsr_q;
    idx_d       = idx_q;
    taps_d      = taps_q;
    pre_len_d   = pre_len_q;
    msg_len_d   = msg_len_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ack_d       = ack_q;

    if (start_ok) begin
      taps_d    = taps_i;
      lfsr_d    = seed_fixed;
      pre_len_d = pre_len_i;
      msg_len_d = msg_len_clamped;
      idx_d     = 6'd0;
      ack_d     = 1'b0;
    end

    // The LFSR only steps together with a byte entering the output slot.
    if (emit) begin
      out_data_d  = {parity, cipher};
      out_valid_d = 1'b1;
      idx_d       = idx_q + 6'd1;
      lfsr_d      = {lfsr_q[5:0], ^(lfsr_q & taps_q)};
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end

    if (state_q == S_DONE && out_valid_q && out_ready_i && !start_ok) begin
      ack_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q      <= 7'h01;
      idx_q       <= 6'd0;
      taps_q      <= 7'h00;
      pre_len_q   <= 4'd0;
      msg_len_q   <= 6'd0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      idx_q       <= idx_d;
      taps_q      <= taps_d;
      pre_len_q   <= pre_len_d;
      msg_len_q   <= msg_len_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ack_q       <= ack_d;
    end
  end

  assign in_ready_o  = in_ready;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign ack_o       = ack_q;

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
// Self-checking bench for lfsr_encrypt_engine: directed vector table, stall/reset sequences,
// and randomized frames against a frame-level reference model (honours ENC_PARITY_EN).
module tb_lfsr_encrypt_engine;

`ifdef ENC_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic [6:0] taps_i;
  logic [6:0] seed_i;
  logic [3:0] pre_len_i;
  logic [5:0] msg_len_i;
  logic [7:0] in_data_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] out_data_o;
  logic       out_valid_o;
  logic       out_ready_i;
  logic       ack_o;

  lfsr_encrypt_engine dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .taps_i     (taps_i),
    .seed_i     (seed_i),
    .pre_len_i  (pre_len_i),
    .msg_len_i  (msg_len_i),
    .in_data_i  (in_data_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .out_data_o (out_data_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .ack_o      (ack_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [6:0] taps;
    logic [6:0] seed;
    logic [3:0] pre;
    logic [5:0] mlen;
    logic [7:0] b0;   // bit 7 = parity bit when parity is built in
    logic [7:0] b1;
    int         hs;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] msg_mem [64];
  logic [7:0] exp_mem [64];
  logic [7:0] rx [$];
  logic [7:0] first_frame [$];
  int         hs_cnt;
  int         viol;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] rx_at(input int i);
    if (i < rx.size()) return rx[i];
    return 8'hxx;
  endfunction

  // Reference: build the 64 plaintext characters, then encrypt with a stepping LFSR.
  task automatic build_expected(input logic [6:0] taps, input logic [6:0] seed,
                                input logic [3:0] pre, input logic [5:0] mlen);
    int         ml;
    int         pl;
    logic [6:0] l;
    logic [6:0] p;
    logic [6:0] c;
    ml = (mlen > 6'd49) ? 49 : int'(mlen);
    pl = int'(pre);
    l  = (seed == 7'h00) ? 7'h01 : seed;
    for (int b = 0; b < 64; b++) begin
      if (b < pl || b >= pl + ml) p = 7'h20;
      else p = msg_mem[b - pl][6:0];
      c = p ^ l;
      exp_mem[b] = {PAR & (^c), c};
      l = {l[5:0], ^(l & taps)};
    end
  endtask

  task automatic check_frame(input string name);
    int mism;
    mism = 0;
    for (int b = 0; b < 64; b++) if (rx_at(b) !== exp_mem[b]) mism++;
    check({name, "_bytes_bad"}, mism, 0);
    check({name, "_len"}, rx.size(), 64);
  endtask

  // mode 0: no stalls; 1: random stalls and ignored mid-frame Starts; 2: directed stall window.
  task automatic run_frame(input logic [6:0] taps, input logic [6:0] seed, input logic [3:0] pre,
                           input logic [5:0] mlen, input int mode, input int abort_at,
                           input bit timing);
    int         ptr;
    bit         holding;
    logic [7:0] held;
    rx.delete();
    hs_cnt  = 0;
    viol    = 0;
    ptr     = 0;
    holding = 1'b0;
    held    = 8'h00;
    @(negedge clk_i);
    start_i = 1'b1; taps_i = taps; seed_i = seed; pre_len_i = pre; msg_len_i = mlen;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    for (int k = 0; k < 400; k++) begin
      out_ready_i = 1'b1;
      in_valid_i  = 1'b1;
      if (mode == 1) begin
        out_ready_i = ($urandom % 4) != 0;
        in_valid_i  = ($urandom % 4) != 0;
        start_i     = (rx.size() < 62) && (($urandom % 8) == 0);
        taps_i = 7'($urandom); seed_i = 7'($urandom);
        pre_len_i = 4'($urandom); msg_len_i = 6'($urandom);
      end else if (mode == 2) begin
        if (k >= 14 && k < 19) out_ready_i = 1'b0;
        if (k >= 19 && k < 22) in_valid_i = 1'b0;
      end
      in_data_i = (ptr < 64) ? msg_mem[ptr] : 8'h00;
      #1;
      if (timing) begin
        if (k == 0)  check("first_valid_early", out_valid_o, 1'b0);
        if (k == 1)  check("first_valid", out_valid_o, 1'b1);
        if (k == 64) check("ack_early", ack_o, 1'b0);
        if (k == 65) check("ack_at_65", ack_o, 1'b1);
      end
      if (holding && (!out_valid_o || out_data_o !== held)) viol++;
      if (out_valid_o && !out_ready_i && in_ready_o) viol++;
      holding = out_valid_o && !out_ready_i;
      held    = out_data_o;
      if (out_valid_o && out_ready_i) rx.push_back(out_data_o);
      if (in_ready_o && in_valid_i) begin
        hs_cnt++;
        ptr++;
      end
      if (abort_at > 0 && rx.size() == abort_at) break;
      if (rx.size() == 64 && ack_o) break;
      @(posedge clk_i);
      @(negedge clk_i);
    end
    start_i    = 1'b0;
    in_valid_i = 1'b0;
  endtask

  task automatic fill_msg();
    for (int b = 0; b < 64; b++) msg_mem[b] = 8'($urandom);
    msg_mem[0] = 8'h4D; msg_mem[1] = 8'h72; msg_mem[2] = 8'h2E;  // "Mr."
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{7'h5C, 7'h01, 4'd10, 6'd3,  8'h21, 8'h22, 3};
    vecs[1] = '{7'h5C, 7'h00, 4'd10, 6'd3,  8'h21, 8'h22, 3};
    vecs[2] = '{7'h5C, 7'h03, 4'd10, 6'd0,  8'hA3, 8'hA6, 0};
    vecs[3] = '{7'h5C, 7'h01, 4'd15, 6'd60, 8'h21, 8'h22, 49};
    vecs[4] = '{7'h5C, 7'h01, 4'd0,  6'd0,  8'h21, 8'h22, 0};
    vecs[5] = '{7'h7F, 7'h40, 4'd1,  6'd49, 8'h60, 8'hCC, 49};

    rst_ni = 1'b0; start_i = 1'b0; taps_i = '0; seed_i = '0; pre_len_i = '0; msg_len_i = '0;
    in_data_i = '0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_out_data", out_data_o, 8'h00);
    check("rst_in_ready", in_ready_o, 1'b0);
    check("rst_ack", ack_o, 1'b0);
    rst_ni = 1'b1;

    for (int e = 0; e < 6; e++) begin
      fill_msg();
      build_expected(vecs[e].taps, vecs[e].seed, vecs[e].pre, vecs[e].mlen);
      run_frame(vecs[e].taps, vecs[e].seed, vecs[e].pre, vecs[e].mlen, 0, 0, e == 0);
      check($sformatf("v%0d_byte0", e), rx_at(0), {PAR & vecs[e].b0[7], vecs[e].b0[6:0]});
      check($sformatf("v%0d_byte1", e), rx_at(1), {PAR & vecs[e].b1[7], vecs[e].b1[6:0]});
      check_frame($sformatf("v%0d", e));
      check($sformatf("v%0d_handshakes", e), hs_cnt, vecs[e].hs);
      check($sformatf("v%0d_ack", e), ack_o, 1'b1);
    end

    // Stalls in the message section must not change a single byte of the stream.
    fill_msg();
    build_expected(7'h5C, 7'h15, 4'd10, 6'd20);
    run_frame(7'h5C, 7'h15, 4'd10, 6'd20, 0, 0, 1'b0);
    first_frame = rx;
    run_frame(7'h5C, 7'h15, 4'd10, 6'd20, 2, 0, 1'b0);
    check("stall_violations", viol, 0);
    check_frame("stall");
    check("stall_same_as_unstalled", (rx == first_frame) ? 1 : 0, 1);
    check("stall_handshakes", hs_cnt, 20);

    // Abort a frame with reset, then run a fresh one.
    run_frame(7'h5C, 7'h01, 4'd10, 6'd3, 0, 30, 1'b0);
    check("abort_reached_30", rx.size(), 30);
    rst_ni = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check("abort_out_valid", out_valid_o, 1'b0);
    check("abort_ack", ack_o, 1'b0);
    check("abort_in_ready", in_ready_o, 1'b0);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    check("idle_no_output", out_valid_o, 1'b0);
    fill_msg();
    build_expected(7'h33, 7'h2A, 4'd4, 6'd12);
    run_frame(7'h33, 7'h2A, 4'd4, 6'd12, 0, 0, 1'b0);
    check_frame("after_reset");
    check("after_reset_ack", ack_o, 1'b1);

    // Randomized frames with random back-pressure and ignored Starts.
    for (int r = 0; r < 8; r++) begin
      logic [6:0] t;
      logic [6:0] s;
      logic [3:0] p;
      logic [5:0] m;
      t = 7'($urandom);
      s = (($urandom % 6) == 0) ? 7'h00 : 7'($urandom);
      p = 4'($urandom);
      m = 6'($urandom);
      fill_msg();
      build_expected(t, s, p, m);
      run_frame(t, s, p, m, 1, 0, 1'b0);
      check_frame($sformatf("rand%0d", r));
      check($sformatf("rand%0d_handshakes", r), hs_cnt, (m > 6'd49) ? 49 : int'(m));
      check($sformatf("rand%0d_stall_violations", r), viol, 0);
      check($sformatf("rand%0d_ack", r), ack_o, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
